// File: rtl/if_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_ctrl
//  Description : IF-stage fetch sequencer. Owns the program counter, issues
//                requests to instruction memory over a ready handshake with
//                variable latency, applies branch redirects and decode stalls,
//                and presents one instruction per accepted fetch at the IF/ID
//                boundary. A one-entry skid buffer absorbs the response that
//                can land while decode is stalled.
//
//  Ports       : clk            - single clock, rising edge
//                rst            - asynchronous reset, active low
//                branch         - redirect request (sampled every cycle)
//                pc_branch      - redirect target (bits [1:0] ignored)
//                stall          - decode cannot accept; hold IF/ID outputs
//                imem_ready     - memory returns imem_rdata this cycle
//                imem_rdata     - instruction word from memory
//                imem_req       - request outstanding
//                imem_addr      - request address (word aligned)
//                Instruction_F  - fetched instruction
//                PcPlus4_F      - address of that instruction + 4
//                valid_F        - Instruction_F / PcPlus4_F are live
//                flush_D        - one-cycle pulse killing the decode slot
//
//  Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch,
    input  logic [31:0] pc_branch,
    input  logic        stall,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] Instruction_F,
    output logic [31:0] PcPlus4_F,
    output logic        valid_F,
    output logic        flush_D
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam logic [31:0] c_WORD_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] c_PC_STEP   = 32'd4;

    // Registered state
    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_redir_pend;
    logic [31:0] r_redir_pc;
    logic        r_skid_v;
    logic [31:0] r_skid_instr;
    logic [31:0] r_skid_pc4;
    logic [31:0] r_instr;
    logic [31:0] r_pc4;
    logic        r_valid;
    logic        r_flush;

    // Next-state values
    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic        w_redir_pend_nxt;
    logic [31:0] w_redir_pc_nxt;
    logic        w_skid_v_nxt;
    logic [31:0] w_skid_instr_nxt;
    logic [31:0] w_skid_pc4_nxt;
    logic [31:0] w_instr_nxt;
    logic [31:0] w_pc4_nxt;
    logic        w_valid_nxt;
    logic        w_flush_nxt;

    logic [31:0] w_branch_tgt;
    logic [31:0] w_pc_plus4;

    assign w_branch_tgt = pc_branch & c_WORD_MASK;
    assign w_pc_plus4   = r_pc + c_PC_STEP;   // wraps modulo 2^32

    // The request is a pure function of the registered state, so it and the
    // address cannot move while a fetch is waiting for imem_ready.
    assign imem_req      = (r_state == ST_FETCH);
    assign imem_addr     = r_pc;
    assign Instruction_F = r_instr;
    assign PcPlus4_F     = r_pc4;
    assign valid_F       = r_valid;
    assign flush_D       = r_flush;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_pc         <= RESET_PC;
            r_redir_pend <= 1'b0;
            r_redir_pc   <= 32'd0;
            r_skid_v     <= 1'b0;
            r_skid_instr <= 32'd0;
            r_skid_pc4   <= 32'd0;
            r_instr      <= 32'd0;
            r_pc4        <= 32'd0;
            r_valid      <= 1'b0;
            r_flush      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_redir_pend <= w_redir_pend_nxt;
            r_redir_pc   <= w_redir_pc_nxt;
            r_skid_v     <= w_skid_v_nxt;
            r_skid_instr <= w_skid_instr_nxt;
            r_skid_pc4   <= w_skid_pc4_nxt;
            r_instr      <= w_instr_nxt;
            r_pc4        <= w_pc4_nxt;
            r_valid      <= w_valid_nxt;
            r_flush      <= w_flush_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_redir_pend_nxt = r_redir_pend;
        w_redir_pc_nxt   = r_redir_pc;
        w_skid_v_nxt     = r_skid_v;
        w_skid_instr_nxt = r_skid_instr;
        w_skid_pc4_nxt   = r_skid_pc4;
        w_instr_nxt      = r_instr;
        w_pc4_nxt        = r_pc4;
        w_valid_nxt      = r_valid;
        w_flush_nxt      = branch;

        // Decode consumes the current word; a bubble remains unless
        // something below loads a new one.
        if (!stall) begin
            w_valid_nxt = 1'b0;
        end

        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_FETCH;
                if (branch) begin
                    w_pc_nxt = w_branch_tgt;
                end
            end

            ST_FETCH: begin
                if (imem_ready) begin
                    if (branch || r_redir_pend) begin
                        // Response belongs to the wrong path; drop it and
                        // restart at the newest target.
                        w_pc_nxt         = branch ? w_branch_tgt : r_redir_pc;
                        w_redir_pend_nxt = 1'b0;
                    end else begin
                        w_pc_nxt = w_pc_plus4;
                        if (!r_valid || !stall) begin
                            w_instr_nxt = imem_rdata;
                            w_pc4_nxt   = w_pc_plus4;
                            w_valid_nxt = 1'b1;
                        end else begin
                            w_skid_v_nxt     = 1'b1;
                            w_skid_instr_nxt = imem_rdata;
                            w_skid_pc4_nxt   = w_pc_plus4;
                            w_state_nxt      = ST_FULL;
                        end
                    end
                end else if (branch) begin
                    // Request cannot be withdrawn: remember the target and
                    // apply it when the in-flight response comes back.
                    w_redir_pend_nxt = 1'b1;
                    w_redir_pc_nxt   = w_branch_tgt;
                end
            end

            ST_FULL: begin
                if (branch) begin
                    w_pc_nxt    = w_branch_tgt;
                    w_state_nxt = ST_FETCH;
                end else if (!stall) begin
                    w_instr_nxt  = r_skid_instr;
                    w_pc4_nxt    = r_skid_pc4;
                    w_valid_nxt  = 1'b1;
                    w_skid_v_nxt = 1'b0;
                    w_state_nxt  = ST_FETCH;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // A branch kills whatever sits at the outputs or in the skid.
        if (branch) begin
            w_valid_nxt  = 1'b0;
            w_skid_v_nxt = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_fetch_ctrl
//  Description : Self-checking bench for if_fetch_ctrl. A queue-based model
//                of the fetch stream is compared every cycle, alongside
//                directed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_ctrl;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DATA_SALT = 32'hDEAD_BEEF;

    logic        clk;
    logic        rst;
    logic        branch;
    logic [31:0] pc_branch;
    logic        stall;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] Instruction_F;
    logic [31:0] PcPlus4_F;
    logic        valid_F;
    logic        flush_D;

    int n_cmp = 0;
    int n_err = 0;

    if_fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .branch       (branch),
        .pc_branch    (pc_branch),
        .stall        (stall),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .Instruction_F(Instruction_F),
        .PcPlus4_F    (PcPlus4_F),
        .valid_F      (valid_F),
        .flush_D      (flush_D)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory responder: fixed wait states ----------------
    int wait_n;
    int wcnt;
    logic ready_force;

    assign imem_ready = ready_force | (imem_req && (wcnt >= wait_n));
    assign imem_rdata = imem_addr ^ DATA_SALT;

    always @(posedge clk or negedge rst) begin
        if (!rst)                        wcnt <= 0;
        else if (imem_req && imem_ready) wcnt <= 0;
        else if (imem_req)               wcnt <= wcnt + 1;
    end

    // ---------------- behavioural model ----------------
    // The fetch stream is a queue of delivered words: head is what decode
    // sees, a second entry is the buffered response. Requests are issued
    // whenever the pipeline has started and fewer than two words are held.
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } ent_t;

    ent_t        m_q[$];
    bit          m_started;
    logic [31:0] m_pc;
    bit          m_redir_v;
    logic [31:0] m_redir;
    bit          m_flush;
    bit          m_req_now;
    logic [31:0] m_tgt;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q.delete();
            m_started = 1'b0;
            m_pc      = RESET_PC;
            m_redir_v = 1'b0;
            m_redir   = 32'd0;
            m_flush   = 1'b0;
        end else begin
            m_req_now = m_started && (m_q.size() < 2);
            m_tgt     = {pc_branch[31:2], 2'b00};
            m_flush   = branch;
            if (branch)
                m_q.delete();
            else if (!stall && m_q.size() > 0)
                void'(m_q.pop_front());
            if (m_req_now && imem_ready) begin
                if (branch || m_redir_v) begin
                    m_pc      = branch ? m_tgt : m_redir;
                    m_redir_v = 1'b0;
                end else begin
                    m_q.push_back('{instr: imem_rdata, pc4: m_pc + 32'd4});
                    m_pc = m_pc + 32'd4;
                end
            end else if (branch) begin
                if (m_req_now) begin
                    m_redir_v = 1'b1;
                    m_redir   = m_tgt;
                end else begin
                    m_pc = m_tgt;
                end
            end
            m_started = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        chk("model_req",   {31'd0, imem_req}, {31'd0, (m_started && m_q.size() < 2)});
        chk("model_addr",  imem_addr, m_pc);
        chk("model_valid", {31'd0, valid_F}, {31'd0, (m_q.size() > 0)});
        chk("model_flush", {31'd0, flush_D}, {31'd0, m_flush});
        if (m_q.size() > 0) begin
            chk("model_instr", Instruction_F, m_q[0].instr);
            chk("model_pc4",   PcPlus4_F,     m_q[0].pc4);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_addr(input logic [31:0] a, input int budget);
        int n = 0;
        while (imem_addr !== a && n < budget) begin
            tick();
            n++;
        end
        chk("wait_addr", imem_addr, a);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"},   {31'd0, imem_req}, 32'd0);
        chk({tag, "_addr"},  imem_addr, RESET_PC);
        chk({tag, "_instr"}, Instruction_F, 32'd0);
        chk({tag, "_pc4"},   PcPlus4_F, 32'd0);
        chk({tag, "_valid"}, {31'd0, valid_F}, 32'd0);
        chk({tag, "_flush"}, {31'd0, flush_D}, 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        branch      = 1'b0;
        pc_branch   = 32'd0;
        stall       = 1'b0;
        wait_n      = 0;
        ready_force = 1'b0;
        #2 rst = 1'b0;
        #1 chk_reset_outputs("rst0");
        tick();
        tick();
        rst = 1'b1;

        // Zero-wait streaming
        tick();
        chk("zw_req0",  {31'd0, imem_req}, 32'd1);
        chk("zw_addr0", imem_addr, 32'h0);
        tick();
        chk("zw_addr4", imem_addr, 32'h4);
        chk("zw_pc4_4", PcPlus4_F, 32'h4);
        chk("zw_ins0",  Instruction_F, 32'hDEAD_BEEF);
        chk("zw_val",   {31'd0, valid_F}, 32'd1);
        tick();
        chk("zw_addr8", imem_addr, 32'h8);
        chk("zw_pc4_8", PcPlus4_F, 32'h8);
        tick();
        chk("zw_addrc", imem_addr, 32'hc);
        chk("zw_pc4_c", PcPlus4_F, 32'hc);

        // Three wait states: address held for four cycles
        wait_n = 3;
        for (int i = 0; i < 4; i++) begin
            chk("ws_addr", imem_addr, 32'hc);
            chk("ws_req",  {31'd0, imem_req}, 32'd1);
            tick();
        end
        chk("ws_next",  imem_addr, 32'h10);
        chk("ws_valid", {31'd0, valid_F}, 32'd1);
        chk("ws_pc4",   PcPlus4_F, 32'h10);
        chk("ws_ins",   Instruction_F, 32'hDEAD_BEE3);

        // Skid: response lands while stalled with a live word
        wait_n = 0;
        stall  = 1'b1;
        tick();
        chk("sk_req",   {31'd0, imem_req}, 32'd0);
        chk("sk_hold",  PcPlus4_F, 32'h10);
        chk("sk_valid", {31'd0, valid_F}, 32'd1);
        tick();
        chk("sk_req2",  {31'd0, imem_req}, 32'd0);
        chk("sk_hold2", PcPlus4_F, 32'h10);
        stall = 1'b0;
        tick();
        chk("sk_out_pc4", PcPlus4_F, 32'h14);
        chk("sk_out_ins", Instruction_F, 32'hDEAD_BEFF);
        chk("sk_resume",  imem_addr, 32'h14);
        chk("sk_req3",    {31'd0, imem_req}, 32'd1);
        tick();
        chk("sk_addr",    imem_addr, 32'h18);

        // Asynchronous reset in the middle of a wait
        wait_n = 2;
        tick();
        #2 rst = 1'b0;
        #1 chk_reset_outputs("arst");
        tick();
        rst = 1'b1;
        tick();
        chk("arst_first", imem_addr, RESET_PC);
        chk("arst_req",   {31'd0, imem_req}, 32'd1);

        // Branch while a 2-wait fetch of 0x10 is outstanding
        wait_addr(32'h10, 40);
        tick();
        branch    = 1'b1;
        pc_branch = 32'h0f0f_0f00;
        tick();
        branch = 1'b0;
        chk("br_flush",  {31'd0, flush_D}, 32'd1);
        chk("br_hold",   imem_addr, 32'h10);
        chk("br_val",    {31'd0, valid_F}, 32'd0);
        tick();
        chk("br_flush0", {31'd0, flush_D}, 32'd0);
        chk("br_tgt",    imem_addr, 32'h0f0f_0f00);
        chk("br_disc",   {31'd0, valid_F}, 32'd0);
        tick();
        tick();
        tick();
        chk("br_val1",   {31'd0, valid_F}, 32'd1);
        chk("br_pc4",    PcPlus4_F, 32'h0f0f_0f04);
        chk("br_ins",    Instruction_F, 32'hD1A2_B1EF);

        // Branch with ready in the same cycle while the skid is full
        wait_n = 0;
        stall  = 1'b1;
        tick();
        chk("bf_full",   {31'd0, imem_req}, 32'd0);
        chk("bf_hold",   PcPlus4_F, 32'h0f0f_0f04);
        branch      = 1'b1;
        pc_branch   = 32'h0000_0103;
        ready_force = 1'b1;
        tick();
        branch      = 1'b0;
        ready_force = 1'b0;
        stall       = 1'b0;
        chk("bf_val",    {31'd0, valid_F}, 32'd0);
        chk("bf_flush",  {31'd0, flush_D}, 32'd1);
        chk("bf_addr",   imem_addr, 32'h0000_0100);
        chk("bf_req",    {31'd0, imem_req}, 32'd1);
        tick();
        chk("bf_val1",   {31'd0, valid_F}, 32'd1);
        chk("bf_pc4",    PcPlus4_F, 32'h0000_0104);
        chk("bf_ins",    Instruction_F, 32'hDEAD_BFEF);
        chk("bf_flush0", {31'd0, flush_D}, 32'd0);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
